// File: rtl/fu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fu_issue_ctrl
//   Multi-cycle issue/sequencing controller for the datapath function unit
//   (ALU + shifter + output mux). Accepts one RV32I integer op (R-type,
//   I-type ALU or conditional branch), drives the FU select/operand lines for
//   exactly one cycle (EXEC), registers the FU result, and turns the FU
//   V/C/N/Z flags into SLT/SLTU values and branch decisions.
//
//   State sequence: IDLE -> EXEC -> DONE            (simple ops)
//                   IDLE -> EXEC -> CMP -> DONE     (SLT/SLTU, branches)
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    op request handshake (in_ready high only in IDLE)
//   in_funct3, in_alt    funct3 and funct7[5] (SUB/SRA select)
//   in_is_imm            I-type ALU op (in_op2 carries the immediate)
//   in_is_branch         conditional branch compare
//   in_op1, in_op2       rs1 value, rs2 value or immediate
//   out_valid/out_ready  result handshake, outputs held stable until accepted
//   out_result           ALU / compare result, 0 for branches
//   out_taken            branch taken, 0 for non-branches
//   out_illegal          branch with funct3 010/011
//   out_flags            {V,C,N,Z} of the op (only with FU_ISSUE_FLAGS_EN)
//   fu_*                 FU control/operands, all 0 outside EXEC
//   fu_f, fu_v..fu_z     FU result and flags, consumed only in EXEC
//
// Configuration
//   FU_ISSUE_FLAGS_EN    when defined, adds out_flags[3:0] = {V,C,N,Z}
//                        captured in EXEC for every op.
// -----------------------------------------------------------------------------
module fu_issue_ctrl #(
   parameter int SIZE = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_funct3,
   input  logic                     in_alt,
   input  logic                     in_is_imm,
   input  logic                     in_is_branch,
   input  logic [SIZE-1:0]          in_op1,
   input  logic [SIZE-1:0]          in_op2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIZE-1:0]          out_result,
   output logic                     out_taken,
   output logic                     out_illegal,
`ifdef FU_ISSUE_FLAGS_EN
   output logic [3:0]               out_flags,
`endif
   output logic [SIZE-1:0]          fu_a,
   output logic [SIZE-1:0]          fu_b,
   output logic [3:0]               fu_g_select,
   output logic [1:0]               fu_h_select,
   output logic [$clog2(SIZE)-1:0]  fu_shamnt,
   output logic                     fu_mf_select,
   output logic                     fu_i_r,
   output logic                     fu_i_l,
   input  logic [SIZE-1:0]          fu_f,
   input  logic                     fu_v,
   input  logic                     fu_c,
   input  logic                     fu_n,
   input  logic                     fu_z
);

   localparam int SW = $clog2(SIZE);

   localparam logic [3:0] G_ADD = 4'b0010;
   localparam logic [3:0] G_SUB = 4'b0101;
   localparam logic [3:0] G_AND = 4'b1000;
   localparam logic [3:0] G_OR  = 4'b1010;
   localparam logic [3:0] G_XOR = 4'b1100;
   localparam logic [1:0] H_SHR = 2'b01;
   localparam logic [1:0] H_SHL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CMP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Branch decision from flags packed as {V,C,N,Z}; illegal funct3 gives 0.
   function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
      logic lt_s;
      logic res;
      lt_s = fl[1] ^ fl[3];
      case (f3)
         3'b000:  res = fl[0];
         3'b001:  res = ~fl[0];
         3'b100:  res = lt_s;
         3'b101:  res = ~lt_s;
         3'b110:  res = ~fl[2];
         3'b111:  res = fl[2];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // SLT uses N^V, SLTU uses the inverted carry (borrow).
   function automatic logic set_less(input logic [2:0] f3, input logic [3:0] fl);
      logic res;
      case (f3)
         3'b010:  res = fl[1] ^ fl[3];
         3'b011:  res = ~fl[2];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              is_branch_q, is_branch_d;
   logic              is_cmp_q, is_cmp_d;
   logic [3:0]        flags_q, flags_d;
   logic [SIZE-1:0]   result_q, result_d;
   logic              taken_q, taken_d;
   logic              illegal_q, illegal_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [SIZE-1:0]   fu_a_q, fu_a_d;
   logic [SIZE-1:0]   fu_b_q, fu_b_d;
   logic [3:0]        fu_g_q, fu_g_d;
   logic [1:0]        fu_h_q, fu_h_d;
   logic [SW-1:0]     fu_sh_q, fu_sh_d;
   logic              fu_mf_q, fu_mf_d;
   logic              fu_ir_q, fu_ir_d;
   logic              fu_il_q, fu_il_d;
`ifdef FU_ISSUE_FLAGS_EN
   logic [3:0]        out_flags_q, out_flags_d;
`endif

   // Decoded FU controls for the op currently offered on the input port.
   logic [SIZE-1:0]   dec_a, dec_b;
   logic [3:0]        dec_g;
   logic [1:0]        dec_h;
   logic [SW-1:0]     dec_sh;
   logic              dec_mf, dec_ir, dec_il, dec_cmp;

   // Translate the incoming op into FU select/operand values.
   always_comb begin
      dec_a   = in_op1;
      dec_b   = in_op2;
      dec_g   = G_ADD;
      dec_h   = 2'b00;
      dec_sh  = '0;
      dec_mf  = 1'b0;
      dec_ir  = 1'b0;
      dec_il  = 1'b0;
      dec_cmp = 1'b0;
      if (in_is_branch) begin
         dec_g   = G_SUB;
         dec_cmp = 1'b1;
      end else begin
         case (in_funct3)
            3'b000: begin
               // ADDI ignores funct7[5]; only the R-type form can be SUB.
               if (!in_is_imm && in_alt) begin
                  dec_g = G_SUB;
               end else begin
                  dec_g = G_ADD;
               end
            end
            3'b001: begin
               // Shifter works on fu_b, so rs1 is routed there.
               dec_a  = '0;
               dec_b  = in_op1;
               dec_g  = 4'b0000;
               dec_h  = H_SHL;
               dec_sh = in_op2[SW-1:0];
               dec_mf = 1'b1;
               dec_il = 1'b0;
            end
            3'b010, 3'b011: begin
               dec_g   = G_SUB;
               dec_cmp = 1'b1;
            end
            3'b100: dec_g = G_XOR;
            3'b101: begin
               dec_a  = '0;
               dec_b  = in_op1;
               dec_g  = 4'b0000;
               dec_h  = H_SHR;
               dec_sh = in_op2[SW-1:0];
               dec_mf = 1'b1;
               // SRA fills with the sign bit, SRL with zero.
               dec_ir = in_alt ? in_op1[SIZE-1] : 1'b0;
            end
            3'b110: dec_g = G_OR;
            3'b111: dec_g = G_AND;
            default: dec_g = G_ADD;
         endcase
      end
   end

   // Next-state and next-register values for the issue sequencer.
   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      is_branch_d = is_branch_q;
      is_cmp_d    = is_cmp_q;
      flags_d     = flags_q;
      result_d    = result_q;
      taken_d     = taken_q;
      illegal_d   = illegal_q;
      // FU drive is only non-zero in the single EXEC cycle after an accept.
      fu_a_d      = '0;
      fu_b_d      = '0;
      fu_g_d      = 4'b0000;
      fu_h_d      = 2'b00;
      fu_sh_d     = '0;
      fu_mf_d     = 1'b0;
      fu_ir_d     = 1'b0;
      fu_il_d     = 1'b0;
`ifdef FU_ISSUE_FLAGS_EN
      out_flags_d = out_flags_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d     = S_EXEC;
               funct3_d    = in_funct3;
               is_branch_d = in_is_branch;
               is_cmp_d    = dec_cmp;
               result_d    = '0;
               taken_d     = 1'b0;
               illegal_d   = 1'b0;
               fu_a_d      = dec_a;
               fu_b_d      = dec_b;
               fu_g_d      = dec_g;
               fu_h_d      = dec_h;
               fu_sh_d     = dec_sh;
               fu_mf_d     = dec_mf;
               fu_ir_d     = dec_ir;
               fu_il_d     = dec_il;
`ifdef FU_ISSUE_FLAGS_EN
               out_flags_d = 4'b0000;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
`ifdef FU_ISSUE_FLAGS_EN
            out_flags_d = {fu_v, fu_c, fu_n, fu_z};
`endif
            if (is_cmp_q) begin
               flags_d = {fu_v, fu_c, fu_n, fu_z};
               state_d = S_CMP;
            end else begin
               result_d = fu_f;
               state_d  = S_DONE;
            end
         end
         S_CMP: begin
            if (is_branch_q) begin
               illegal_d = (funct3_q[2:1] == 2'b01);
               taken_d   = branch_taken(funct3_q, flags_q);
            end else begin
               result_d = {{(SIZE-1){1'b0}}, set_less(funct3_q, flags_q)};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         funct3_q    <= 3'b000;
         is_branch_q <= 1'b0;
         is_cmp_q    <= 1'b0;
         flags_q     <= 4'b0000;
         result_q    <= '0;
         taken_q     <= 1'b0;
         illegal_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         fu_a_q      <= '0;
         fu_b_q      <= '0;
         fu_g_q      <= 4'b0000;
         fu_h_q      <= 2'b00;
         fu_sh_q     <= '0;
         fu_mf_q     <= 1'b0;
         fu_ir_q     <= 1'b0;
         fu_il_q     <= 1'b0;
`ifdef FU_ISSUE_FLAGS_EN
         out_flags_q <= 4'b0000;
`endif
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         is_branch_q <= is_branch_d;
         is_cmp_q    <= is_cmp_d;
         flags_q     <= flags_d;
         result_q    <= result_d;
         taken_q     <= taken_d;
         illegal_q   <= illegal_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         fu_a_q      <= fu_a_d;
         fu_b_q      <= fu_b_d;
         fu_g_q      <= fu_g_d;
         fu_h_q      <= fu_h_d;
         fu_sh_q     <= fu_sh_d;
         fu_mf_q     <= fu_mf_d;
         fu_ir_q     <= fu_ir_d;
         fu_il_q     <= fu_il_d;
`ifdef FU_ISSUE_FLAGS_EN
         out_flags_q <= out_flags_d;
`endif
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_result   = result_q;
   assign out_taken    = taken_q;
   assign out_illegal  = illegal_q;
`ifdef FU_ISSUE_FLAGS_EN
   assign out_flags    = out_flags_q;
`endif
   assign fu_a         = fu_a_q;
   assign fu_b         = fu_b_q;
   assign fu_g_select  = fu_g_q;
   assign fu_h_select  = fu_h_q;
   assign fu_shamnt    = fu_sh_q;
   assign fu_mf_select = fu_mf_q;
   assign fu_i_r       = fu_ir_q;
   assign fu_i_l       = fu_il_q;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed self-checking bench for fu_issue_ctrl with a behavioural FU model.
module tb_fu_issue_ctrl;

   localparam int SIZE = 32;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_funct3 = 3'b000;
   logic        in_alt = 1'b0;
   logic        in_is_imm = 1'b0;
   logic        in_is_branch = 1'b0;
   logic [31:0] in_op1 = 32'd0;
   logic [31:0] in_op2 = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        out_taken;
   logic        out_illegal;
`ifdef FU_ISSUE_FLAGS_EN
   logic [3:0]  out_flags;
`endif
   logic [31:0] fu_a, fu_b, fu_f;
   logic [3:0]  fu_g_select;
   logic [1:0]  fu_h_select;
   logic [4:0]  fu_shamnt;
   logic        fu_mf_select, fu_i_r, fu_i_l;
   logic        fu_v, fu_c, fu_n, fu_z;

   int checks = 0;
   int errors = 0;

   fu_issue_ctrl #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_alt(in_alt), .in_is_imm(in_is_imm),
      .in_is_branch(in_is_branch), .in_op1(in_op1), .in_op2(in_op2),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_taken(out_taken), .out_illegal(out_illegal),
`ifdef FU_ISSUE_FLAGS_EN
      .out_flags(out_flags),
`endif
      .fu_a(fu_a), .fu_b(fu_b), .fu_g_select(fu_g_select),
      .fu_h_select(fu_h_select), .fu_shamnt(fu_shamnt),
      .fu_mf_select(fu_mf_select), .fu_i_r(fu_i_r), .fu_i_l(fu_i_l),
      .fu_f(fu_f), .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z)
   );

   always #5 clk = ~clk;

   // Behavioural function unit: ALU, shifter, output mux and flags.
   logic [32:0] m_sum;
   logic [31:0] m_alu, m_shr, m_shl, m_sh;
   always_comb begin
      m_sum = 33'd0;
      m_alu = 32'd0;
      fu_v  = 1'b0;
      fu_c  = 1'b0;
      case (fu_g_select)
         4'b0010: begin
            m_sum = {1'b0, fu_a} + {1'b0, fu_b};
            m_alu = m_sum[31:0];
            fu_c  = m_sum[32];
            fu_v  = (fu_a[31] == fu_b[31]) && (m_alu[31] != fu_a[31]);
         end
         4'b0101: begin
            m_sum = {1'b0, fu_a} + {1'b0, ~fu_b} + 33'd1;
            m_alu = m_sum[31:0];
            fu_c  = m_sum[32];
            fu_v  = (fu_a[31] != fu_b[31]) && (m_alu[31] != fu_a[31]);
         end
         4'b1000: m_alu = fu_a & fu_b;
         4'b1010: m_alu = fu_a | fu_b;
         4'b1100: m_alu = fu_a ^ fu_b;
         default: m_alu = 32'd0;
      endcase
      m_shr = (fu_b >> fu_shamnt) | (fu_i_r ? ~(ONES >> fu_shamnt) : 32'd0);
      m_shl = (fu_b << fu_shamnt) | (fu_i_l ? ~(ONES << fu_shamnt) : 32'd0);
      if (fu_h_select == 2'b01) m_sh = m_shr;
      else if (fu_h_select == 2'b10) m_sh = m_shl;
      else m_sh = fu_b;
      fu_f = fu_mf_select ? m_sh : m_alu;
      fu_n = fu_f[31];
      fu_z = (fu_f == 32'd0);
   end

   // Offer an op and return #1 after the edge that accepts it.
   task automatic issue(input logic [2:0] f3, input logic alt, input logic imm,
                        input logic br, input logic [31:0] a, input logic [31:0] b);
      int n;
      in_funct3 = f3; in_alt = alt; in_is_imm = imm; in_is_branch = br;
      in_op1 = a; in_op2 = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL issue_timeout: in_ready stayed %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges from the accept edge (counted as 1) until out_valid rises.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   // Let the accepted result retire (out_ready is expected high).
   task automatic finish_op();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h, required 0", out_result); end
      checks++; if ({out_taken, out_illegal} !== 2'b00) begin errors++; $display("FAIL rst_taken_illegal: got %b, required 00", {out_taken, out_illegal}); end
      checks++; if ({fu_a, fu_b, fu_g_select, fu_h_select, fu_mf_select} !== 71'd0) begin errors++; $display("FAIL rst_fu_zero: got %h, required 0", {fu_a, fu_b, fu_g_select, fu_h_select, fu_mf_select}); end
   endtask

   task automatic test_add();
      int lat;
      out_ready = 1'b1;
      issue(3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7);
      checks++; if ({fu_g_select, fu_a, fu_b} !== {4'b0010, 32'd5, 32'd7}) begin errors++; $display("FAIL add_fu_drive: got g=%b a=%h b=%h, required g=0010 a=5 b=7", fu_g_select, fu_a, fu_b); end
      wait_done(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d, required 2", lat); end
      checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result: got %h, required %h", out_result, 32'd12); end
      checks++; if (out_taken !== 1'b0) begin errors++; $display("FAIL add_taken: got %b, required 0", out_taken); end
      checks++; if (fu_g_select !== 4'b0000) begin errors++; $display("FAIL add_fu_idle: got %b, required 0000", fu_g_select); end
`ifdef FU_ISSUE_FLAGS_EN
      checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b, required 0000", out_flags); end
`endif
      finish_op();
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL add_retire: got valid/ready %b, required 01", {out_valid, in_ready}); end
   endtask

   task automatic test_sub_addi();
      int lat;
      issue(3'b000, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
      wait_done(lat);
      checks++; if (out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h, required fffffffe", out_result); end
      finish_op();
      issue(3'b000, 1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
      checks++; if (fu_g_select !== 4'b0010) begin errors++; $display("FAIL addi_g: got %b, required 0010", fu_g_select); end
      wait_done(lat);
      checks++; if (out_result !== 32'd8) begin errors++; $display("FAIL addi_result: got %h, required 8", out_result); end
      finish_op();
   endtask

   task automatic test_shifts();
      int lat;
      issue(3'b101, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
      checks++; if ({fu_mf_select, fu_h_select, fu_i_r, fu_shamnt, fu_b} !== {1'b1, 2'b01, 1'b1, 5'd4, 32'h8000_0000}) begin errors++; $display("FAIL sra_fu_drive: got mf=%b h=%b ir=%b sh=%0d b=%h", fu_mf_select, fu_h_select, fu_i_r, fu_shamnt, fu_b); end
      wait_done(lat);
      checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result: got %h, required f8000000", out_result); end
      finish_op();
      issue(3'b101, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
      wait_done(lat);
      checks++; if (out_result !== 32'h0800_0000) begin errors++; $display("FAIL srl_result: got %h, required 08000000", out_result); end
      finish_op();
      issue(3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'd31);
      checks++; if (fu_h_select !== 2'b10) begin errors++; $display("FAIL sll_h: got %b, required 10", fu_h_select); end
      wait_done(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sll_latency: got %0d, required 2", lat); end
      checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL sll_result: got %h, required 80000000", out_result); end
      finish_op();
   endtask

   task automatic test_compare();
      // {funct3, is_branch, op1, op2, expected result, expected taken}
      logic [2:0]  t_f3  [7] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b000, 3'b001};
      logic        t_br  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] t_a   [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd9};
      logic [31:0] t_b   [7] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd9, 32'd9};
      logic [31:0] t_res [7] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      logic        t_tk  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 7; i++) begin
         issue(t_f3[i], 1'b0, 1'b0, t_br[i], t_a[i], t_b[i]);
         checks++; if ({fu_g_select, fu_a, fu_b} !== {4'b0101, t_a[i], t_b[i]}) begin errors++; $display("FAIL cmp%0d_fu_drive: got g=%b a=%h b=%h", i, fu_g_select, fu_a, fu_b); end
         wait_done(lat);
         checks++; if (lat !== 3) begin errors++; $display("FAIL cmp%0d_latency: got %0d, required 3", i, lat); end
         checks++; if (out_result !== t_res[i]) begin errors++; $display("FAIL cmp%0d_result: got %h, required %h", i, out_result, t_res[i]); end
         checks++; if (out_taken !== t_tk[i]) begin errors++; $display("FAIL cmp%0d_taken: got %b, required %b", i, out_taken, t_tk[i]); end
         checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL cmp%0d_illegal: got %b, required 0", i, out_illegal); end
`ifdef FU_ISSUE_FLAGS_EN
         if (i == 0) begin
            checks++; if (out_flags !== 4'b0110) begin errors++; $display("FAIL cmp_flags: got %b, required 0110", out_flags); end
         end
`endif
         finish_op();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      issue(3'b110, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F);
      wait_done(lat);
      // A new request is held by the producer while the result is stalled.
      in_funct3 = 3'b000; in_alt = 1'b0; in_is_imm = 1'b0; in_is_branch = 1'b0;
      in_op1 = 32'd100; in_op2 = 32'd1; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++; if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 32'h0000_00FF}) begin errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b result=%h, required 1 0 000000ff", k, out_valid, in_ready, out_result); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid/ready %b, required 01", {out_valid, in_ready}); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got in_ready %b, required 0", in_ready); end
      wait_done(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL bp_next_latency: got %0d, required 2", lat); end
      checks++; if (out_result !== 32'd101) begin errors++; $display("FAIL bp_next_result: got %h, required %h", out_result, 32'd101); end
      finish_op();
   endtask

   task automatic test_reset_mid_op();
      int lat;
      issue(3'b000, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if ({out_valid, out_taken, in_ready} !== 3'b001) begin errors++; $display("FAIL rstmid_state: got valid/taken/ready %b, required 001", {out_valid, out_taken, in_ready}); end
      checks++; if (fu_g_select !== 4'b0000) begin errors++; $display("FAIL rstmid_fu: got %b, required 0000", fu_g_select); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got out_valid %b, required 0", out_valid); end
      issue(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
      wait_done(lat);
      checks++; if (out_result !== 32'd2) begin errors++; $display("FAIL rstmid_add: got %h, required 2", out_result); end
      finish_op();
   endtask

   task automatic test_illegal();
      int lat;
      issue(3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
      wait_done(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL illegal_latency: got %0d, required 3", lat); end
      checks++; if ({out_illegal, out_taken} !== 2'b10) begin errors++; $display("FAIL illegal_flags: got illegal/taken %b, required 10", {out_illegal, out_taken}); end
      checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL illegal_result: got %h, required 0", out_result); end
      finish_op();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_addi();
      test_shifts();
      test_compare();
      test_backpressure();
      test_reset_mid_op();
      test_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
